multicycle_seq_ctrl: RTL and testbench
======================================

Name: multicycle_seq_ctrl

Overview:
- Multicycle fetch/decode/execute/writeback sequencer that sits directly upstream of the register file cells.
- Fetches 32-bit instructions over a simple req/ack memory port and decodes the rs/rt/rd fields.
- Presents rs/rt to the register file, captures both read operands, and runs a small integer ALU.
- Drives the rd address and write data back for one writeback cycle per instruction.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'h3F, opcode that parks the sequencer in HALT.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  instruction fetch request, held until ack.
- imem_addr  output  32  fetch address (= pc).
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  32  fetched instruction.
- rs  output  5  register file read port A select.
- rt  output  5  register file read port B select.
- rd  output  5  register file write select.
- wr_data  output  32  writeback data.
- wr_en  output  1  writeback strobe, exactly one cycle.
- rd_data_a  input  32  register file port A data.
- rd_data_b  input  32  register file port B data.
- halted  output  1  high while in HALT.
- illegal  output  1  sticky, set on an undecodable instruction.
- pc  output  32  current program counter.

Behaviour:
- Reset, on rst low, immediate and asynchronous, including mid-instruction:
  - state=FETCH, pc=PC_RESET, imem_req=0, rs=rt=rd=0, wr_data=0, wr_en=0, halted=0, illegal=0.
  - The instruction register (ir) and operand latches clear to 0.
  - An outstanding fetch is abandoned; a late imem_ack is ignored unless it arrives after re-entry to FETCH.
- Instruction format: opcode=ir[31:26], rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], imm=ir[15:0] sign-extended to 32 bits, funct=ir[5:0].
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stays in FETCH while imem_ack=0.
  - On imem_ack=1: ir<=imem_rdata, imem_req<=0, go to DECODE.
- DECODE (1 cycle):
  - Drive rs/rt outputs from ir.
  - opcode==HALT_OP goes to HALT.
  - opcode 6'h00 or 6'h08 goes to READ.
  - Any other opcode sets illegal=1, pc<=pc+4, and goes to FETCH.
- READ (1 cycle):
  - rs/rt held stable; the register file settles.
  - At end of cycle, A<=rd_data_a, B<=rd_data_b; go to EXEC.
- EXEC (1 cycle), result computed modulo 2^32:
  - opcode 6'h00 selects on funct:
    - 6'h20 ADD: A+B.
    - 6'h22 SUB: A-B.
    - 6'h24 AND: A&B.
    - 6'h25 OR: A|B.
    - 6'h2A SLT: signed compare, result 1 or 0.
    - Other funct: illegal=1, no writeback, pc<=pc+4, go to FETCH.
  - opcode 6'h08 ADDI: A+sext(imm); destination is rt.
  - Valid result: wr_data<=result, rd<=destination, go to WB.
- WB (1 cycle):
  - wr_en=1, unless destination==0, in which case wr_en stays 0 (r0 never written).
  - pc<=pc+4, go to FETCH.
  - wr_en is 0 in every other state.
- Timing: each legal ALU instruction takes 4 cycles plus the fetch wait (FETCH>=1, DECODE, READ, EXEC, WB).
- HALT:
  - halted=1, imem_req=0; stays in HALT until reset.
  - pc points at the HALT instruction.
- Hold rules:
  - rs/rt/rd hold their last value outside their driving states; they are never X.
  - wr_data and rd must be stable throughout the wr_en cycle.
- pc wraps from 32'hFFFF_FFFC to 0 with no flag.
- illegal is sticky until reset; execution continues after an illegal instruction.
- Simultaneous imem_ack and reset: reset wins.

Test Plan:
- Reset then first fetch: release rst and return imem_ack after 3 cycles with 32'h0022_1820 (ADD r3,r1,r2), rd_data_a=5, rd_data_b=7 -> imem_addr=0, rs=1, rt=2; wr_en pulses once with rd=3, wr_data=12; next imem_addr=4.
- ADDI negative immediate: ir=32'h2025_FFFF (ADDI r5,r1,-1), rd_data_a=0 -> rd=5, wr_data=32'hFFFF_FFFF, wr_en one cycle.
- SLT signed: A=32'hFFFF_FFFE, B=1, funct 6'h2A, rd=4 -> wr_data=1; swapping operands -> wr_data=0.
- r0 suppression: ADD r0,r1,r2 -> wr_en stays 0 throughout; pc still advances by 4.
- Illegal then HALT: ir=32'h1000_0000 -> illegal=1, no wr_en, pc+4; next ir=32'hFC00_0000 -> halted=1, imem_req stays 0 for 20+ cycles, pc frozen.
- Reset mid-EXEC: assert rst during EXEC of an ADD -> outputs go to reset values immediately, no wr_en; after release, the fetch restarts at PC_RESET.

Source files
------------

// File: rtl/multicycle_seq_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_seq_ctrl
//   Multicycle fetch / decode / read / execute / writeback sequencer that sits
//   directly in front of the register file. One instruction is in flight at a
//   time. Each legal ALU op takes FETCH (>=1 cycle, waits for imem_ack),
//   DECODE, READ, EXEC and WB.
//
// Parameters
//   PC_RESET   pc value loaded on reset
//   HALT_OP    opcode that parks the sequencer in HALT until reset
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   imem_req/addr     fetch request (held until ack) and fetch address (= pc)
//   imem_ack/rdata    fetch data valid strobe and instruction word
//   rs, rt            register file read selects (ports A / B)
//   rd_data_a/b       register file read data
//   rd, wr_data       writeback select and data, stable across the wr_en cycle
//   wr_en             one-cycle writeback strobe (never for r0)
//   halted            high while parked in HALT
//   illegal           sticky flag, set on an undecodable opcode or funct
//   pc                current program counter
// ---------------------------------------------------------------------------
module multicycle_seq_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] wr_data,
    output logic        wr_en,
    input  logic [31:0] rd_data_a,
    input  logic [31:0] rd_data_b,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] pc
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [2:0]  state;
    logic [31:0] ir;
    logic [31:0] op_a;
    logic [31:0] op_b;

    // instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;

    assign opcode   = ir[31:26];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    // ALU: only meaningful in EXEC, where opcode is already known to be
    // RTYPE or ADDI. alu_ok low means an unsupported funct.
    logic [31:0] alu_res;
    logic [4:0]  alu_dest;
    logic        alu_ok;

    always_comb begin
        alu_res  = '0;
        alu_dest = ir[15:11];
        alu_ok   = 1'b0;
        if (opcode == OP_ADDI) begin
            alu_res  = op_a + imm_sext;
            alu_dest = ir[20:16];
            alu_ok   = 1'b1;
        end else begin
            alu_ok = 1'b1;
            case (funct)
                FN_ADD:  alu_res = op_a + op_b;
                FN_SUB:  alu_res = op_a - op_b;
                FN_AND:  alu_res = op_a & op_b;
                FN_OR:   alu_res = op_a | op_b;
                FN_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
                default: alu_ok  = 1'b0;
            endcase
        end
    end

    logic decode_legal;
    assign decode_legal = (opcode == OP_RTYPE) || (opcode == OP_ADDI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            imem_req <= 1'b0;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rs       <= '0;
            rt       <= '0;
            rd       <= '0;
            wr_data  <= '0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // After reset the request comes up one cycle late, so an
                    // ack that was still high across reset release is never
                    // mistaken for a response to a new request.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        // Load selects alongside ir so they already reflect
                        // ir during DECODE and stay put through READ.
                        rs       <= imem_rdata[25:21];
                        rt       <= imem_rdata[20:16];
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == HALT_OP) begin
                        state <= S_HALT;
                    end else if (decode_legal) begin
                        state <= S_READ;
                    end else begin
                        illegal  <= 1'b1;
                        pc       <= pc + 32'd4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_READ: begin
                    op_a  <= rd_data_a;
                    op_b  <= rd_data_b;
                    state <= S_READ + 3'd1;
                end
                S_EXEC: begin
                    if (alu_ok) begin
                        wr_data <= alu_res;
                        rd      <= alu_dest;
                        state   <= S_WB;
                    end else begin
                        illegal  <= 1'b1;
                        pc       <= pc + 32'd4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_WB: begin
                    // pc wraps modulo 2^32 with no flag
                    pc       <= pc + 32'd4;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    state    <= S_HALT;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    // r0 is hardwired: its writeback is suppressed rather than skipped so the
    // instruction timing is identical for every destination.
    assign wr_en     = (state == S_WB) && (rd != 5'd0);

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_seq_ctrl
//   Directed + randomized bench for multicycle_seq_ctrl. A small instruction
//   memory responder and register file live in the bench; expected writeback,
//   pc, illegal and per-instruction cycle counts come from an instruction-level
//   reference model.
// ---------------------------------------------------------------------------
module tb_multicycle_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [4:0]  rs, rt, rd;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] rd_data_a, rd_data_b;
    logic        halted, illegal;
    logic [31:0] pc;

    logic [31:0] regs [32];
    assign rd_data_a = regs[rs];
    assign rd_data_b = regs[rt];

    multicycle_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rs(rs), .rt(rt), .rd(rd),
        .wr_data(wr_data), .wr_en(wr_en),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .halted(halted), .illegal(illegal), .pc(pc)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // architectural model state
    logic [31:0] m_pc;
    logic        m_illegal;
    logic [31:0] last_wdat;
    logic [4:0]  last_wrd;
    int          last_wcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] imm);
        return {6'h08, s, t, imm};
    endfunction

    // kind: 0 legal ALU op, 1 illegal opcode, 2 illegal funct, 3 halt
    task automatic model(input logic [31:0] ins, output int kind,
                         output logic [31:0] res, output logic [4:0] dest);
        logic [31:0] a, b;
        a = regs[ins[25:21]];
        b = regs[ins[20:16]];
        res = '0; dest = '0; kind = 0;
        if (ins[31:26] == 6'h3F) kind = 3;
        else if (ins[31:26] == 6'h08) begin
            dest = ins[20:16];
            res  = a + {{16{ins[15]}}, ins[15:0]};
        end else if (ins[31:26] == 6'h00) begin
            dest = ins[15:11];
            case (ins[5:0])
                6'h20: res = a + b;
                6'h22: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: kind = 2;
            endcase
        end else kind = 1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int lat);
        int kind, n, wr_cnt, exp_n, exp_wr;
        logic [31:0] res, w_dat;
        logic [4:0]  dest, w_rd;
        model(ins, kind, res, dest);
        wait_req();
        chk("fetch_addr", imem_addr, m_pc);
        repeat (lat) @(negedge clk);
        chk("req_held", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = ins;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        wr_cnt = 0; w_rd = '0; w_dat = '0; n = 0;
        while (imem_req !== 1'b1 && halted !== 1'b1 && n < 12) begin
            if (n == 1 && kind == 0) begin
                chk("rs_sel", {27'd0, rs}, {27'd0, ins[25:21]});
                chk("rt_sel", {27'd0, rt}, {27'd0, ins[20:16]});
            end
            if (wr_en === 1'b1) begin wr_cnt++; w_rd = rd; w_dat = wr_data; end
            @(negedge clk); n++;
        end
        exp_n  = (kind == 0) ? 4 : (kind == 2) ? 3 : 1;
        exp_wr = (kind == 0 && dest != 5'd0) ? 1 : 0;
        chk("seq_cycles", n, exp_n);
        chk("wr_count", wr_cnt, exp_wr);
        if (exp_wr == 1) begin
            chk("wb_rd", {27'd0, w_rd}, {27'd0, dest});
            chk("wb_data", w_dat, res);
            regs[dest] = res;
        end
        if (kind == 1 || kind == 2) m_illegal = 1'b1;
        if (kind != 3) m_pc = m_pc + 32'd4;
        chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
        chk("pc", pc, m_pc);
        chk("halted", {31'd0, halted}, (kind == 3) ? 32'd1 : 32'd0);
        last_wdat = w_dat; last_wrd = w_rd; last_wcnt = wr_cnt;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},     {31'd0, imem_req}, 32'd0);
        chk({tag, "_pc"},      pc, 32'd0);
        chk({tag, "_rs_rt_rd"}, {17'd0, rs, rt, rd}, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_flags"},   {29'd0, wr_en, halted, illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn_list [5];
        logic [5:0] op;
        int sel;
        fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        sel = $urandom_range(0, 9);
        if (sel <= 5)
            return rtype(5'($urandom), 5'($urandom), 5'($urandom), fn_list[$urandom_range(0, 4)]);
        else if (sel <= 7)
            return addi(5'($urandom), 5'($urandom), 16'($urandom));
        else if (sel == 8)
            return rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h01);
        op = 6'($urandom_range(9, 62));
        return {op, 26'($urandom)};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        logic [31:0] pc_hold;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = '0;
        m_pc = 32'd0; m_illegal = 1'b0;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;

        // ADD r3,r1,r2 with a 3-cycle fetch wait
        regs[1] = 32'd5; regs[2] = 32'd7;
        run_instr(32'h0022_1820, 3);
        chk("add_result", last_wdat, 32'd12);
        wait_req();
        chk("next_addr", imem_addr, 32'd4);

        // ADDI r5,r1,-1 with A = 0
        regs[1] = 32'd0;
        run_instr(32'h2025_FFFF, 1);
        chk("addi_neg", last_wdat, 32'hFFFF_FFFF);
        chk("addi_rd", {27'd0, last_wrd}, 32'd5);

        // SLT signed, both operand orders
        regs[6] = 32'hFFFF_FFFE; regs[7] = 32'd1;
        run_instr(rtype(5'd6, 5'd7, 5'd4, 6'h2A), 0);
        chk("slt_lt", last_wdat, 32'd1);
        run_instr(rtype(5'd7, 5'd6, 5'd4, 6'h2A), 2);
        chk("slt_ge", last_wdat, 32'd0);

        // writeback to r0 suppressed
        run_instr(32'h0022_0020, 1);
        chk("r0_no_wb", last_wcnt, 0);

        // randomized instruction stream
        for (int i = 0; i < 40; i++) run_instr(rand_instr(), $urandom_range(0, 4));

        // illegal funct sets the flag; then reset in the middle of EXEC
        run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h01), 0);
        run_instr(rtype(5'd1, 5'd2, 5'd9, 6'h20), 0);
        wait_req();
        imem_ack = 1'b1; imem_rdata = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        @(negedge clk);               // DECODE
        imem_ack = 1'b0;
        @(negedge clk);               // READ
        @(negedge clk);               // EXEC
        rst = 1'b0;
        imem_ack = 1'b1;              // ack colliding with reset must be lost
        #1;
        chk_reset_vals("rst_exec");
        viol = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_en !== 1'b0) viol++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (wr_en !== 1'b0) viol++;
        chk("rst_no_wb", viol, 0);
        chk("rst_restart_pc", pc, 32'd0);
        imem_ack = 1'b0;
        m_pc = 32'd0; m_illegal = 1'b0;
        run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h22), 1);

        // illegal opcode then HALT
        run_instr(32'h1000_0000, 1);
        pc_hold = m_pc;
        run_instr(32'hFC00_0000, 0);
        viol = 0;
        repeat (25) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || halted !== 1'b1 || wr_en !== 1'b0 || pc !== pc_hold) viol++;
        end
        chk("halt_hold", viol, 0);
        chk("halt_pc", pc, pc_hold);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
